id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Parametrised ID->EX pipeline register. It replaces the fixed always-advance latch.
- Adds a valid/ready handshake, stall back-pressure, flush, and an optional 1-entry skid buffer.
- It also decodes memop and writeEnable from exop, so EX sees a registered, stall-safe bundle.
- Sits between ID and EX.

Parameters:
- INST_W, 32, instruction width
- WORD_W, 32, operand width
- REG_ADDR_W, 5, register address width
- EXOP_HI_W, 3, alusel field width (upper bits of exop)
- EXOP_LO_W, 5, aluop field width (lower bits of exop)
- MEMOP_W, 2, memop width
- SKID_EN, 1, 1 = skid buffer and registered id_ready; 0 = no skid and combinational id_ready

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all held and incoming entries
- id_valid  in  1  ID offers an entry
- id_ready  out  1  stage accepts an entry this cycle
- id_inst  in  INST_W  instruction
- id_exop  in  EXOP_HI_W+EXOP_LO_W  {alusel, aluop}
- id_srcLeft  in  WORD_W  left operand
- id_srcRight  in  WORD_W  right operand
- id_dest  in  REG_ADDR_W  destination register
- ex_valid  out  1  entry presented to EX
- ex_ready  in  1  EX consumes the entry this cycle
- ex_inst  out  INST_W  instruction
- ex_alusel  out  EXOP_HI_W  alusel
- ex_aluop  out  EXOP_LO_W  aluop
- ex_srcLeft  out  WORD_W  left operand
- ex_srcRight  out  WORD_W  right operand
- ex_memop  out  MEMOP_W  memory op
- ex_dest  out  REG_ADDR_W  destination register
- ex_writeEnable  out  1  register writeback enable

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On rst: ex_valid=0, skid empty.
  - All ex_* outputs take BUBBLE values: inst 0, alusel EX_HIGH_SPECIAL, aluop EX_SPECIAL_NOP, srcs 0, memop MEM_OP_NOP, dest REG_ZERO, writeEnable 0.
  - id_ready=1 (SKID_EN=1) in the cycle after reset.
- Handshakes:
  - accept = id_valid & id_ready.
  - drain = ex_valid & ex_ready.
- Latency: an accepted entry appears on ex_* with ex_valid=1 the next cycle. Throughput is 1/cycle while ex_ready=1.
- Decode at capture (the payload is stored already decoded):
  - alusel LOGIC or ARITH: memop = MEM_OP_WRITE_REG, we=1.
  - alusel MEMACC: memop = {id_exop[3], 1'b1}, we=0.
  - Otherwise: memop = NOP, we=0.
  - dest==REG_ZERO forces we=0 in every case.
- FSM (SKID_EN=1): EMPTY, FULL (output reg valid), SKID (output and skid regs valid).
  - EMPTY: accept -> FULL.
  - FULL, accept & drain: stay FULL, output reg loads the new entry.
  - FULL, accept & !drain: -> SKID, new entry goes into the skid reg.
  - FULL, drain & !accept: -> EMPTY, outputs load BUBBLE.
  - SKID, drain: -> FULL, skid reg moves to the output reg.
  - SKID: no accept is possible.
- id_ready (SKID_EN=1) is registered: 1 in EMPTY and FULL, 0 in SKID.
- SKID_EN=0: id_ready = ex_ready | ~ex_valid (combinational). States are EMPTY and FULL only.
- ex_* outputs hold stable while ex_valid & ~ex_ready. Whenever ex_valid=0, ex_* show BUBBLE values.
- Flush:
  - Next state EMPTY, skid cleared, outputs BUBBLE.
  - An entry accepted in the flush cycle is discarded.
  - Flush has priority over accept and drain.
  - rst has priority over flush.
- Reset mid-SKID: both entries are lost and there is no partial drain.

Decomposition:
- The existing shared defines package holds EX_HIGH_*, EX_SPECIAL_NOP, MEM_OP_*, REG_ZERO and ENABLE/DISABLE.
- Add a BUBBLE payload constant there.
- One sub-module, id_ex_decode: combinational exop/dest -> {memop, writeEnable}. It is shared with any later issue-stage variants.

Test Plan:
- Stream: ex_ready=1, send exop ARITH/ADD with dest 3, then LOGIC/OR with dest 4 on consecutive cycles -> each appears on ex_* one cycle later, memop WRITE_REG, we=1, ex_valid continuous.
- Stall into skid: with ex_ready=0, send A then B -> state SKID, id_ready=0, ex_* hold A. Raise ex_ready -> A then B drain in order, id_ready back to 1.
- Flush in SKID holding A and B, with id_valid=1 carrying C -> next cycle ex_valid=0, ex_* BUBBLE, C not captured, id_ready=1.
- MEMACC with id_exop[3]=1 and dest 7 -> memop 2'b11, we=0. ARITH with dest 0 -> memop WRITE_REG, we=0.
- rst asserted in FULL with ex_ready=0 -> next cycle all outputs BUBBLE, ex_valid=0. Repeat the stall test with SKID_EN=0 -> id_ready falls in the same cycle as ex_ready=0.

Source files
------------

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared ID/EX defines: exop field codes, memop codes, register constants,
// the BUBBLE payload and the pipeline register state encoding.
package id_ex_pipe_reg_pkg;

    // alusel codes (upper exop field)
    localparam logic [2:0] EX_HIGH_SPECIAL = 3'd0;
    localparam logic [2:0] EX_HIGH_LOGIC   = 3'd1;
    localparam logic [2:0] EX_HIGH_ARITH   = 3'd2;
    localparam logic [2:0] EX_HIGH_MEMACC  = 3'd3;

    // aluop code that does nothing inside the SPECIAL group
    localparam logic [4:0] EX_SPECIAL_NOP = 5'd0;

    // memop codes; MEMACC builds {dir, 1'b1} so it never collides with these
    localparam logic [1:0] MEM_OP_NOP       = 2'b00;
    localparam logic [1:0] MEM_OP_WRITE_REG = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Decoded ID->EX payload at the default widths
    typedef struct packed {
        logic [31:0] inst;
        logic [2:0]  alusel;
        logic [4:0]  aluop;
        logic [31:0] src_left;
        logic [31:0] src_right;
        logic [1:0]  memop;
        logic [4:0]  dest;
        logic        write_enable;
    } ex_payload_t;

    // Harmless no-op presented to EX whenever no valid entry is held
    localparam ex_payload_t BUBBLE = '{
        inst:         32'd0,
        alusel:       EX_HIGH_SPECIAL,
        aluop:        EX_SPECIAL_NOP,
        src_left:     32'd0,
        src_right:    32'd0,
        memop:        MEM_OP_NOP,
        dest:         REG_ZERO,
        write_enable: DISABLE
    };

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/id_ex_decode.sv
// Combinational exop/dest decode into the memory op and writeback enable.
module id_ex_decode
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int EXOP_HI_W  = 3,
    parameter int REG_ADDR_W = 5,
    parameter int MEMOP_W    = 2
) (
    input  logic [EXOP_HI_W-1:0]  alusel,
    input  logic                  mem_dir,
    input  logic [REG_ADDR_W-1:0] dest,
    output logic [MEMOP_W-1:0]    memop,
    output logic                  write_enable
);

    // Classify by alusel; writes to the zero register are always suppressed
    always_comb begin
        memop        = MEMOP_W'(MEM_OP_NOP);
        write_enable = DISABLE;
        if (alusel == EXOP_HI_W'(EX_HIGH_LOGIC) || alusel == EXOP_HI_W'(EX_HIGH_ARITH)) begin
            memop        = MEMOP_W'(MEM_OP_WRITE_REG);
            write_enable = ENABLE;
        end else if (alusel == EXOP_HI_W'(EX_HIGH_MEMACC)) begin
            memop = MEMOP_W'({mem_dir, 1'b1});
        end
        if (dest == REG_ADDR_W'(REG_ZERO)) begin
            write_enable = DISABLE;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid/ready handshake, flush and an
// optional one-entry skid buffer. The payload is decoded at capture.
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int INST_W     = 32,
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int EXOP_HI_W  = 3,
    parameter int EXOP_LO_W  = 5,
    parameter int MEMOP_W    = 2,
    parameter bit SKID_EN    = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           id_valid,
    output logic                           id_ready,
    input  logic [INST_W-1:0]              id_inst,
    input  logic [EXOP_HI_W+EXOP_LO_W-1:0] id_exop,
    input  logic [WORD_W-1:0]              id_srcLeft,
    input  logic [WORD_W-1:0]              id_srcRight,
    input  logic [REG_ADDR_W-1:0]          id_dest,
    output logic                           ex_valid,
    input  logic                           ex_ready,
    output logic [INST_W-1:0]              ex_inst,
    output logic [EXOP_HI_W-1:0]           ex_alusel,
    output logic [EXOP_LO_W-1:0]           ex_aluop,
    output logic [WORD_W-1:0]              ex_srcLeft,
    output logic [WORD_W-1:0]              ex_srcRight,
    output logic [MEMOP_W-1:0]             ex_memop,
    output logic [REG_ADDR_W-1:0]          ex_dest,
    output logic                           ex_writeEnable
);

    localparam int EXOP_W = EXOP_HI_W + EXOP_LO_W;

    pipe_state_t state, state_next;
    logic        ready_q;
    logic        accept, drain;
    logic        load_out, load_skid, skid_to_out;
    logic [MEMOP_W-1:0] dec_memop;
    logic               dec_we;

    // Held entries: output register and skid register (data only, no reset)
    logic [INST_W-1:0]     out_inst,  skid_inst;
    logic [EXOP_W-1:0]     out_exop,  skid_exop;
    logic [WORD_W-1:0]     out_left,  skid_left;
    logic [WORD_W-1:0]     out_right, skid_right;
    logic [MEMOP_W-1:0]    out_memop, skid_memop;
    logic [REG_ADDR_W-1:0] out_dest,  skid_dest;
    logic                  out_we,    skid_we;

    id_ex_decode #(
        .EXOP_HI_W (EXOP_HI_W),
        .REG_ADDR_W(REG_ADDR_W),
        .MEMOP_W   (MEMOP_W)
    ) u_decode (
        .alusel      (id_exop[EXOP_LO_W +: EXOP_HI_W]),
        .mem_dir     (id_exop[3]),
        .dest        (id_dest),
        .memop       (dec_memop),
        .write_enable(dec_we)
    );

    assign ex_valid = (state != ST_EMPTY);
    // Without the skid buffer, ready follows EX directly so a stall never needs storage
    assign id_ready = SKID_EN ? ready_q : (ex_ready | ~ex_valid);
    assign accept   = id_valid & id_ready;
    assign drain    = ex_valid & ex_ready;

    // Next state and register load controls; flush overrides everything
    always_comb begin
        state_next  = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FULL;
                    load_out   = 1'b1;
                end
            end
            ST_FULL: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_next = ST_SKID;
                    load_skid  = 1'b1;
                end else if (drain) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (drain) begin
                    state_next  = ST_FULL;
                    skid_to_out = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (flush) begin
            state_next  = ST_EMPTY;
            load_out    = 1'b0;
            load_skid   = 1'b0;
            skid_to_out = 1'b0;
        end
    end

    // State register and registered ready (low only while the skid is occupied)
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != ST_SKID);
        end
    end

    // Payload capture: output reg from ID or from the skid, skid reg from ID
    always_ff @(posedge clk) begin
        if (load_out) begin
            out_inst  <= id_inst;
            out_exop  <= id_exop;
            out_left  <= id_srcLeft;
            out_right <= id_srcRight;
            out_memop <= dec_memop;
            out_dest  <= id_dest;
            out_we    <= dec_we;
        end else if (skid_to_out) begin
            out_inst  <= skid_inst;
            out_exop  <= skid_exop;
            out_left  <= skid_left;
            out_right <= skid_right;
            out_memop <= skid_memop;
            out_dest  <= skid_dest;
            out_we    <= skid_we;
        end
        if (load_skid) begin
            skid_inst  <= id_inst;
            skid_exop  <= id_exop;
            skid_left  <= id_srcLeft;
            skid_right <= id_srcRight;
            skid_memop <= dec_memop;
            skid_dest  <= id_dest;
            skid_we    <= dec_we;
        end
    end

    // EX sees the held entry when valid, otherwise the BUBBLE no-op
    always_comb begin
        ex_inst        = INST_W'(BUBBLE.inst);
        ex_alusel      = EXOP_HI_W'(BUBBLE.alusel);
        ex_aluop       = EXOP_LO_W'(BUBBLE.aluop);
        ex_srcLeft     = WORD_W'(BUBBLE.src_left);
        ex_srcRight    = WORD_W'(BUBBLE.src_right);
        ex_memop       = MEMOP_W'(BUBBLE.memop);
        ex_dest        = REG_ADDR_W'(BUBBLE.dest);
        ex_writeEnable = BUBBLE.write_enable;
        if (ex_valid) begin
            ex_inst        = out_inst;
            ex_alusel      = out_exop[EXOP_LO_W +: EXOP_HI_W];
            ex_aluop       = out_exop[EXOP_LO_W-1:0];
            ex_srcLeft     = out_left;
            ex_srcRight    = out_right;
            ex_memop       = out_memop;
            ex_dest        = out_dest;
            ex_writeEnable = out_we;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: one instance with the skid buffer,
// one without, each checked against hand-computed values.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0, id_valid_b = 1'b0;
    logic        ex_ready = 1'b0, ex_ready_b = 1'b0;
    logic [31:0] id_inst = '0, id_srcLeft = '0, id_srcRight = '0;
    logic [7:0]  id_exop = '0;
    logic [4:0]  id_dest = '0;

    logic        id_ready, ex_valid, ex_we;
    logic [31:0] ex_inst, ex_left, ex_right;
    logic [2:0]  ex_alusel;
    logic [4:0]  ex_aluop, ex_dest;
    logic [1:0]  ex_memop;

    logic        id_ready_b, ex_valid_b, ex_we_b;
    logic [31:0] ex_inst_b, ex_left_b, ex_right_b;
    logic [2:0]  ex_alusel_b;
    logic [4:0]  ex_aluop_b, ex_dest_b;
    logic [1:0]  ex_memop_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_exop(id_exop),
        .id_srcLeft(id_srcLeft), .id_srcRight(id_srcRight), .id_dest(id_dest),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_inst(ex_inst), .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
        .ex_srcLeft(ex_left), .ex_srcRight(ex_right), .ex_memop(ex_memop),
        .ex_dest(ex_dest), .ex_writeEnable(ex_we)
    );

    id_ex_pipe_reg #(.SKID_EN(1'b0)) dut_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid_b), .id_ready(id_ready_b),
        .id_inst(id_inst), .id_exop(id_exop),
        .id_srcLeft(id_srcLeft), .id_srcRight(id_srcRight), .id_dest(id_dest),
        .ex_valid(ex_valid_b), .ex_ready(ex_ready_b),
        .ex_inst(ex_inst_b), .ex_alusel(ex_alusel_b), .ex_aluop(ex_aluop_b),
        .ex_srcLeft(ex_left_b), .ex_srcRight(ex_right_b), .ex_memop(ex_memop_b),
        .ex_dest(ex_dest_b), .ex_writeEnable(ex_we_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [7:0] exop, input logic [4:0] dest);
        id_inst     = inst;
        id_exop     = exop;
        id_dest     = dest;
        id_srcLeft  = inst + 32'd1;
        id_srcRight = inst + 32'd2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total_cnt++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %0h want 0", ex_valid); else pass_cnt++;
        total_cnt++; if (id_ready !== 1'b1) $display("FAIL reset_ready got %0h want 1", id_ready); else pass_cnt++;
        total_cnt++; if (ex_inst !== 32'd0) $display("FAIL reset_inst got %0h want 0", ex_inst); else pass_cnt++;
        total_cnt++; if (ex_alusel !== 3'd0 || ex_aluop !== 5'd0) $display("FAIL reset_exop got %0h/%0h want 0/0", ex_alusel, ex_aluop); else pass_cnt++;
        total_cnt++; if (ex_left !== 32'd0 || ex_right !== 32'd0) $display("FAIL reset_srcs got %0h/%0h want 0/0", ex_left, ex_right); else pass_cnt++;
        total_cnt++; if (ex_memop !== 2'b00 || ex_dest !== 5'd0 || ex_we !== 1'b0) $display("FAIL reset_mem got %0h/%0h/%0h want 0/0/0", ex_memop, ex_dest, ex_we); else pass_cnt++;
    endtask

    task automatic test_stream();
        ex_ready = 1'b1;
        id_valid = 1'b1;
        drive(32'h0000_1111, 8'h41, 5'd3);   // ARITH / ADD
        step();
        total_cnt++; if (ex_valid !== 1'b1 || ex_inst !== 32'h0000_1111) $display("FAIL stream_a got v=%0h inst=%0h want v=1 inst=1111", ex_valid, ex_inst); else pass_cnt++;
        total_cnt++; if (ex_alusel !== 3'd2 || ex_aluop !== 5'd1 || ex_dest !== 5'd3) $display("FAIL stream_a_fields got %0h/%0h/%0h want 2/1/3", ex_alusel, ex_aluop, ex_dest); else pass_cnt++;
        total_cnt++; if (ex_memop !== 2'b10 || ex_we !== 1'b1) $display("FAIL stream_a_dec got %0h/%0h want 2/1", ex_memop, ex_we); else pass_cnt++;
        total_cnt++; if (ex_left !== 32'h0000_1112 || ex_right !== 32'h0000_1113) $display("FAIL stream_a_srcs got %0h/%0h want 1112/1113", ex_left, ex_right); else pass_cnt++;
        drive(32'h0000_2222, 8'h22, 5'd4);   // LOGIC / OR
        step();
        total_cnt++; if (ex_valid !== 1'b1 || ex_inst !== 32'h0000_2222) $display("FAIL stream_b got v=%0h inst=%0h want v=1 inst=2222", ex_valid, ex_inst); else pass_cnt++;
        total_cnt++; if (ex_alusel !== 3'd1 || ex_dest !== 5'd4 || ex_memop !== 2'b10 || ex_we !== 1'b1) $display("FAIL stream_b_dec got %0h/%0h/%0h/%0h want 1/4/2/1", ex_alusel, ex_dest, ex_memop, ex_we); else pass_cnt++;
        id_valid = 1'b0;
        step();
        total_cnt++; if (ex_valid !== 1'b0 || ex_inst !== 32'd0) $display("FAIL stream_empty got v=%0h inst=%0h want 0/0", ex_valid, ex_inst); else pass_cnt++;
    endtask

    task automatic test_skid();
        ex_ready = 1'b0;
        id_valid = 1'b1;
        drive(32'h0000_00AA, 8'h41, 5'd3);
        step();
        total_cnt++; if (id_ready !== 1'b1 || ex_inst !== 32'h0000_00AA) $display("FAIL skid_full got rdy=%0h inst=%0h want 1/aa", id_ready, ex_inst); else pass_cnt++;
        drive(32'h0000_00BB, 8'h22, 5'd4);
        step();
        total_cnt++; if (id_ready !== 1'b0) $display("FAIL skid_ready got %0h want 0", id_ready); else pass_cnt++;
        total_cnt++; if (ex_inst !== 32'h0000_00AA || ex_valid !== 1'b1) $display("FAIL skid_hold_a got %0h v=%0h want aa v=1", ex_inst, ex_valid); else pass_cnt++;
        id_valid = 1'b0;
        step();
        total_cnt++; if (ex_inst !== 32'h0000_00AA || ex_dest !== 5'd3) $display("FAIL skid_stable got %0h/%0h want aa/3", ex_inst, ex_dest); else pass_cnt++;
        ex_ready = 1'b1;
        step();
        total_cnt++; if (ex_inst !== 32'h0000_00BB || ex_dest !== 5'd4 || ex_valid !== 1'b1) $display("FAIL skid_drain_b got %0h/%0h v=%0h want bb/4 v=1", ex_inst, ex_dest, ex_valid); else pass_cnt++;
        total_cnt++; if (id_ready !== 1'b1) $display("FAIL skid_ready_back got %0h want 1", id_ready); else pass_cnt++;
        step();
        total_cnt++; if (ex_valid !== 1'b0) $display("FAIL skid_empty got %0h want 0", ex_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        id_valid = 1'b1;
        drive(32'h0000_0A0A, 8'h41, 5'd3);
        step();
        drive(32'h0000_0B0B, 8'h41, 5'd5);
        step();
        total_cnt++; if (id_ready !== 1'b0) $display("FAIL flush_pre_skid got %0h want 0", id_ready); else pass_cnt++;
        drive(32'h0000_0C0C, 8'h41, 5'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        total_cnt++; if (ex_valid !== 1'b0 || ex_inst !== 32'd0 || ex_memop !== 2'b00 || ex_we !== 1'b0) $display("FAIL flush_bubble got v=%0h inst=%0h mem=%0h we=%0h want 0/0/0/0", ex_valid, ex_inst, ex_memop, ex_we); else pass_cnt++;
        total_cnt++; if (id_ready !== 1'b1) $display("FAIL flush_ready got %0h want 1", id_ready); else pass_cnt++;
        id_valid = 1'b0;
        ex_ready = 1'b1;
        step();
        total_cnt++; if (ex_valid !== 1'b0) $display("FAIL flush_c_dropped got %0h want 0", ex_valid); else pass_cnt++;
    endtask

    task automatic test_decode();
        ex_ready = 1'b1;
        id_valid = 1'b1;
        drive(32'h0000_0D0D, 8'h68, 5'd7);   // MEMACC, exop[3]=1
        step();
        total_cnt++; if (ex_memop !== 2'b11 || ex_we !== 1'b0) $display("FAIL dec_memacc got %0h/%0h want 3/0", ex_memop, ex_we); else pass_cnt++;
        drive(32'h0000_0E0E, 8'h60, 5'd7);   // MEMACC, exop[3]=0
        step();
        total_cnt++; if (ex_memop !== 2'b01 || ex_we !== 1'b0) $display("FAIL dec_memacc_lo got %0h/%0h want 1/0", ex_memop, ex_we); else pass_cnt++;
        drive(32'h0000_0F0F, 8'h41, 5'd0);   // ARITH to the zero register
        step();
        total_cnt++; if (ex_memop !== 2'b10 || ex_we !== 1'b0) $display("FAIL dec_zero_dest got %0h/%0h want 2/0", ex_memop, ex_we); else pass_cnt++;
        drive(32'h0000_1010, 8'h05, 5'd5);   // SPECIAL
        step();
        total_cnt++; if (ex_memop !== 2'b00 || ex_we !== 1'b0 || ex_aluop !== 5'd5) $display("FAIL dec_special got %0h/%0h/%0h want 0/0/5", ex_memop, ex_we, ex_aluop); else pass_cnt++;
        id_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_full();
        ex_ready = 1'b0;
        id_valid = 1'b1;
        drive(32'h0000_5555, 8'h41, 5'd9);
        step();
        total_cnt++; if (ex_valid !== 1'b1 || ex_inst !== 32'h0000_5555) $display("FAIL rstfull_pre got v=%0h inst=%0h want 1/5555", ex_valid, ex_inst); else pass_cnt++;
        id_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++; if (ex_valid !== 1'b0 || ex_inst !== 32'd0 || ex_dest !== 5'd0 || ex_we !== 1'b0) $display("FAIL rstfull_bubble got v=%0h inst=%0h dest=%0h we=%0h want 0/0/0/0", ex_valid, ex_inst, ex_dest, ex_we); else pass_cnt++;
        total_cnt++; if (ex_alusel !== 3'd0 || ex_aluop !== 5'd0 || ex_left !== 32'd0 || id_ready !== 1'b1) $display("FAIL rstfull_misc got %0h/%0h/%0h rdy=%0h want 0/0/0 rdy=1", ex_alusel, ex_aluop, ex_left, id_ready); else pass_cnt++;
    endtask

    task automatic test_noskid();
        ex_ready_b = 1'b1;
        id_valid_b = 1'b1;
        drive(32'h0000_7777, 8'h41, 5'd3);
        step();
        total_cnt++; if (ex_valid_b !== 1'b1 || ex_inst_b !== 32'h0000_7777 || id_ready_b !== 1'b1) $display("FAIL noskid_a got v=%0h inst=%0h rdy=%0h want 1/7777/1", ex_valid_b, ex_inst_b, id_ready_b); else pass_cnt++;
        ex_ready_b = 1'b0;
        drive(32'h0000_8888, 8'h22, 5'd4);
        #1;
        total_cnt++; if (id_ready_b !== 1'b0) $display("FAIL noskid_ready_comb got %0h want 0", id_ready_b); else pass_cnt++;
        step();
        total_cnt++; if (ex_inst_b !== 32'h0000_7777 || ex_valid_b !== 1'b1) $display("FAIL noskid_hold got %0h v=%0h want 7777 v=1", ex_inst_b, ex_valid_b); else pass_cnt++;
        ex_ready_b = 1'b1;
        #1;
        total_cnt++; if (id_ready_b !== 1'b1) $display("FAIL noskid_ready_up got %0h want 1", id_ready_b); else pass_cnt++;
        step();
        total_cnt++; if (ex_inst_b !== 32'h0000_8888 || ex_dest_b !== 5'd4 || ex_we_b !== 1'b1) $display("FAIL noskid_b got %0h/%0h/%0h want 8888/4/1", ex_inst_b, ex_dest_b, ex_we_b); else pass_cnt++;
        id_valid_b = 1'b0;
        step();
        total_cnt++; if (ex_valid_b !== 1'b0 || ex_inst_b !== 32'd0) $display("FAIL noskid_empty got v=%0h inst=%0h want 0/0", ex_valid_b, ex_inst_b); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_decode();
        test_reset_full();
        test_noskid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
